// File: rtl/interrupt_controller_8_pkg.sv
// Shared types and sizes for the 8-source interrupt controller.
package interrupt_controller_8_pkg;

  localparam int NUM_SRC = 8;
  localparam int VEC_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACKD = 2'd2
  } state_t;

endpackage

// File: rtl/priority_encoder_8to3.sv
// 8-to-3 priority encoder: the highest set input index wins; valid flags any set bit.
module priority_encoder_8to3
  import interrupt_controller_8_pkg::*;
(
  input  logic [NUM_SRC-1:0] din,
  output logic [VEC_W-1:0]   dout,
  output logic               valid
);

  always_comb begin
    dout  = '0;
    valid = 1'b0;
    // Ascending scan so a higher index overrides any lower one.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (din[i]) begin
        dout  = VEC_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller_8.sv
// 8-source interrupt controller: edge/level capture into pending, masking,
// fixed priority (bit 7 highest) and a non-preemptive irq/ack handshake.
module interrupt_controller_8
  import interrupt_controller_8_pkg::*;
#(
  parameter int EDGE_TRIG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_din,
  input  logic               ack,
  output logic               irq,
  output logic [VEC_W-1:0]   vector,
  output logic [NUM_SRC-1:0] pending,
  output state_t             state
);

  // Handshake: irq/vector are held stable from entry into REQ until the
  // consumer pulses ack for one cycle; ack outside REQ has no effect, and
  // irq stays low for at least one cycle (ACKD) between requests.

  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] edge_term;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] clr_vec;
  logic [VEC_W-1:0]   enc_vec;
  logic               any_req;

  assign edge_term = (EDGE_TRIG != 0) ? (irq_in & ~irq_q) : irq_in;
  assign active    = pending & ~mask;

  priority_encoder_8to3 u_enc (
    .din   (active),
    .dout  (enc_vec),
    .valid (any_req)
  );

  always_comb begin
    clr_vec = '0;
    if (state == REQ && ack) clr_vec[vector] = 1'b1;
  end

  // Set is ORed in after the clear so a same-edge new request survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~clr_vec) | edge_term;
      if (mask_wr) mask <= mask_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      irq    <= 1'b0;
      vector <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= REQ;
            vector <= enc_vec;
            irq    <= 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            state <= ACKD;
            irq   <= 1'b0;
          end
        end
        ACKD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller_8.sv
// Directed bench for interrupt_controller_8 with hand-computed expectations.
module tb_interrupt_controller_8;
  import interrupt_controller_8_pkg::*;

  logic         clk;
  logic         rst;
  logic [7:0]   irq_in;
  logic         mask_wr;
  logic [7:0]   mask_din;
  logic         ack;
  logic         irq;
  logic [2:0]   vector;
  logic [7:0]   pending;
  state_t       state;

  int tests_run;
  int tests_failed;

  interrupt_controller_8 #(.EDGE_TRIG(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .mask_wr  (mask_wr),
    .mask_din (mask_din),
    .ack      (ack),
    .irq      (irq),
    .vector   (vector),
    .pending  (pending),
    .state    (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge, then settle 1 ns before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_in = 8'h00; mask_wr = 1'b0; mask_din = 8'h00; ack = 1'b0;
    step(); step();
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b want 0", irq); end
    tests_run++; if (vector !== 3'd0) begin tests_failed++; $display("FAIL reset_vector: got %0d want 0", vector); end
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL reset_pending: got %h want 00", pending); end
    tests_run++; if (state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want IDLE", state); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    irq_in = 8'h01;
    step();
    tests_run++; if (pending !== 8'h01) begin tests_failed++; $display("FAIL single_pending_set: got %h want 01", pending); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL single_irq_early: got %b want 0", irq); end
    irq_in = 8'h00;
    step();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL single_irq: got %b want 1", irq); end
    tests_run++; if (vector !== 3'd0) begin tests_failed++; $display("FAIL single_vector: got %0d want 0", vector); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL single_irq_ack: got %b want 0", irq); end
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL single_pending_clr: got %h want 00", pending); end
    tests_run++; if (state !== ACKD) begin tests_failed++; $display("FAIL single_ackd: got %0d want ACKD", state); end
    step();
    tests_run++; if (state !== IDLE) begin tests_failed++; $display("FAIL single_idle: got %0d want IDLE", state); end
  endtask

  task automatic test_priority();
    irq_in = 8'h42;
    step();
    irq_in = 8'h00;
    step();
    tests_run++; if (irq !== 1'b1 || vector !== 3'd6) begin tests_failed++; $display("FAIL prio_first: got irq=%b vec=%0d want irq=1 vec=6", irq, vector); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests_run++; if (pending !== 8'h02) begin tests_failed++; $display("FAIL prio_pending: got %h want 02", pending); end
    step();
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL prio_gap: got irq=%b want 0", irq); end
    step();
    tests_run++; if (irq !== 1'b1 || vector !== 3'd1) begin tests_failed++; $display("FAIL prio_second: got irq=%b vec=%0d want irq=1 vec=1", irq, vector); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL prio_done: got %h want 00", pending); end
    step();
  endtask

  task automatic test_mask();
    mask_wr = 1'b1; mask_din = 8'h80;
    step();
    mask_wr = 1'b0;
    irq_in = 8'h81;
    step();
    irq_in = 8'h00;
    tests_run++; if (pending !== 8'h81) begin tests_failed++; $display("FAIL mask_pending: got %h want 81", pending); end
    step();
    tests_run++; if (irq !== 1'b1 || vector !== 3'd0) begin tests_failed++; $display("FAIL mask_vector: got irq=%b vec=%0d want irq=1 vec=0", irq, vector); end
    // Masking the in-service source must not withdraw irq.
    mask_wr = 1'b1; mask_din = 8'h81;
    step();
    mask_wr = 1'b0;
    tests_run++; if (irq !== 1'b1 || vector !== 3'd0) begin tests_failed++; $display("FAIL mask_inservice: got irq=%b vec=%0d want irq=1 vec=0", irq, vector); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests_run++; if (pending !== 8'h80) begin tests_failed++; $display("FAIL mask_kept: got %h want 80", pending); end
    mask_wr = 1'b1; mask_din = 8'h00;
    step();
    mask_wr = 1'b0;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL mask_gap: got irq=%b want 0", irq); end
    step();
    tests_run++; if (irq !== 1'b1 || vector !== 3'd7) begin tests_failed++; $display("FAIL mask_unmask: got irq=%b vec=%0d want irq=1 vec=7", irq, vector); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
  endtask

  task automatic test_no_preempt();
    irq_in = 8'h04;
    step();
    irq_in = 8'h00;
    step();
    tests_run++; if (irq !== 1'b1 || vector !== 3'd2) begin tests_failed++; $display("FAIL nopre_first: got irq=%b vec=%0d want irq=1 vec=2", irq, vector); end
    irq_in = 8'h80;
    step();
    irq_in = 8'h00;
    tests_run++; if (pending !== 8'h84) begin tests_failed++; $display("FAIL nopre_pending: got %h want 84", pending); end
    step();
    tests_run++; if (irq !== 1'b1 || vector !== 3'd2) begin tests_failed++; $display("FAIL nopre_hold: got irq=%b vec=%0d want irq=1 vec=2", irq, vector); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    step();
    tests_run++; if (irq !== 1'b1 || vector !== 3'd7) begin tests_failed++; $display("FAIL nopre_next: got irq=%b vec=%0d want irq=1 vec=7", irq, vector); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
  endtask

  task automatic test_collision();
    irq_in = 8'h08;
    step();
    irq_in = 8'h00;
    step();
    tests_run++; if (irq !== 1'b1 || vector !== 3'd3) begin tests_failed++; $display("FAIL coll_first: got irq=%b vec=%0d want irq=1 vec=3", irq, vector); end
    ack = 1'b1; irq_in = 8'h08;
    step();
    ack = 1'b0; irq_in = 8'h00;
    tests_run++; if (pending !== 8'h08) begin tests_failed++; $display("FAIL coll_setwins: got %h want 08", pending); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL coll_irq_low: got %b want 0", irq); end
    step();
    step();
    tests_run++; if (irq !== 1'b1 || vector !== 3'd3) begin tests_failed++; $display("FAIL coll_rereq: got irq=%b vec=%0d want irq=1 vec=3", irq, vector); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL coll_done: got %h want 00", pending); end
    step();
  endtask

  task automatic test_ack_ignored();
    ack = 1'b1;
    step();
    step();
    ack = 1'b0;
    tests_run++; if (state !== IDLE || irq !== 1'b0) begin tests_failed++; $display("FAIL ack_idle: got state=%0d irq=%b want IDLE 0", state, irq); end
  endtask

  task automatic test_reset_mid();
    irq_in = 8'h30;
    step();
    irq_in = 8'h00;
    step();
    tests_run++; if (irq !== 1'b1 || vector !== 3'd5) begin tests_failed++; $display("FAIL rstmid_req: got irq=%b vec=%0d want irq=1 vec=5", irq, vector); end
    rst = 1'b1;
    #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL rstmid_irq: got %b want 0", irq); end
    tests_run++; if (vector !== 3'd0) begin tests_failed++; $display("FAIL rstmid_vector: got %0d want 0", vector); end
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL rstmid_pending: got %h want 00", pending); end
    // Line already high at release counts as a rising edge.
    irq_in = 8'h01;
    step();
    rst = 1'b0;
    step();
    tests_run++; if (pending !== 8'h01) begin tests_failed++; $display("FAIL rst_release_edge: got %h want 01", pending); end
    step();
    tests_run++; if (irq !== 1'b1 || vector !== 3'd0) begin tests_failed++; $display("FAIL rst_release_req: got irq=%b vec=%0d want irq=1 vec=0", irq, vector); end
    irq_in = 8'h00; ack = 1'b1;
    step();
    ack = 1'b0;
    step();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_no_preempt();
    test_collision();
    test_ack_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/interrupt_controller_8.md
INTERRUPT_CONTROLLER_8 -- requirements
Module: interrupt_controller_8

Interface
REQ-001 Parameter: EDGE_TRIG, default 1, meaning 1 = a source sets pending on the rising edge of irq_in[i], 0 = a source sets pending while irq_in[i] is high.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: irq_in  input  8  raw interrupt request lines; bit 7 has highest priority.
REQ-005 Port: mask_wr  input  1  write strobe for the mask register.
REQ-006 Port: mask_din  input  8  mask write data; 1 = source disabled.
REQ-007 Port: ack  input  1  one-cycle acknowledge from the consumer of irq/vector.
REQ-008 Port: irq  output  1  interrupt request to the consumer; registered.
REQ-009 Port: vector  output  3  index of the serviced source; registered; valid while irq = 1.
REQ-010 Port: pending  output  8  current pending register, for status readback.

Function
REQ-011 Register irq_in into irq_q every cycle; with EDGE_TRIG=1, the edge term is irq_in & ~irq_q; with EDGE_TRIG=0, the edge term is irq_in.
REQ-012 Set each pending bit whose edge term is 1 on the same clock edge that samples the edge term.
REQ-013 Form the active request word as pending & ~mask and encode it with 8-to-3 priority: the highest set index wins, and any_req = OR of the active word.
REQ-014 Implement an FSM with three states: IDLE, REQ, ACKD.
REQ-015 In IDLE, if any_req = 1, move to REQ, latch vector from the encoder output, and set irq = 1, all on the same edge.
REQ-016 Consequence of REQ-012 and REQ-015: an irq_in rise sampled at edge E0 sets pending at E0, and irq/vector become visible after edge E1 (latency 2 edges).
REQ-017 In REQ, hold irq and vector stable and do not pre-empt, even if a higher-priority source becomes pending.
REQ-018 In REQ, when ack = 1, clear pending[vector], clear irq, and move to ACKD.
REQ-019 In ACKD, unconditionally return to IDLE after one cycle, so irq stays low for at least one full cycle between requests.
REQ-020 Ignore ack in IDLE and in ACKD.
REQ-021 When mask_wr = 1, load mask from mask_din on that edge.
REQ-022 Masking a source does not clear its pending bit; unmasking it later makes it eligible again.
REQ-023 Masking the source currently in REQ does not withdraw irq; the request completes normally.
REQ-024 Set and clear collide when, on the edge that clears pending[vector] (REQ-018), the same source also has a new edge term; in that case the set wins and the bit stays 1.
REQ-025 Edges on other sources that arrive during REQ or ACKD are captured in pending and arbitrated on the next IDLE.
REQ-026 If pending & ~mask is nonzero on the edge that returns the FSM to IDLE, the controller enters REQ one edge later.

Reset
REQ-027 While rst = 1, asynchronously force: state = IDLE, irq = 0, vector = 3'b000, pending = 8'h00, mask = 8'h00 (all sources enabled), irq_q = 8'h00.
REQ-028 Reset asserted mid-request drops irq immediately, without waiting for a clock edge, and discards all pending requests.
REQ-029 After rst deasserts, an irq_in line that is already high counts as a rising edge on the first clock when EDGE_TRIG = 1, because irq_q resets to 0.

Structure
REQ-030 A shared package holds the FSM state enum (IDLE, REQ, ACKD), NUM_SRC = 8, and VEC_W = 3.
REQ-031 The priority encoding is one sub-module instance, priority_encoder_8to3 (din 8, dout 3, valid 1), fed with pending & ~mask; its valid output drives any_req.
REQ-032 Target size of the top level is about 120-200 lines of RTL.

Verification
REQ-033 The bench shall cover the single-source case: reset, then pulse irq_in = 8'h01 -> irq = 1 and vector = 0 two edges later; ack -> irq = 0 and pending = 8'h00.
REQ-034 The bench shall cover the priority case: irq_in = 8'h42 in one cycle -> vector = 6; ack -> after the ACKD gap, vector = 1; ack -> pending = 8'h00.
REQ-035 The bench shall cover masking: write mask = 8'h80, then irq_in = 8'h81 -> vector = 0; ack; write mask = 8'h00 -> vector = 7 is served next.
REQ-036 The bench shall cover no pre-emption: source 2 is in REQ when source 7 rises -> vector stays 2 until ack, then vector = 7 after the ACKD gap.
REQ-037 The bench shall cover set/clear collision: source 3 is in REQ and a new source-3 edge lands on the ack edge -> pending[3] stays 1 and source 3 is re-requested.
REQ-038 The bench shall cover reset mid-request: assert rst while irq = 1 -> irq, vector and pending go to 0 before the next clock edge.
